// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl - IFU fetch sequencer.
//   Generates the fetch PC stream (boot vector, sequential +4, BPU redirect,
//   EXU flush redirect), tracks in-flight instruction-memory requests in a
//   PC FIFO, drops responses of squashed requests and tags survivors with PC.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   flush_vld_i / flush_pc_i         EXU redirect strobe and target
//   bpu_taken_i, bpu_op1_i/op2_i     BPU taken flag for the offered response,
//                                    target = op1 + op2
//   pc_req_vld_o/rdy_i/addr_o        fetch request channel
//   mem_rsp_vld_i / mem_rsp_rdy_o    instruction-memory response channel
//   ifu_rsp_vld_o/rdy_i/pc_o         surviving response toward BPU/decode
module ifu_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RST_PC   = 32'h8000_0000,
  parameter int                MAX_OUTS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_vld_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              bpu_taken_i,
  input  logic [ADDR_W-1:0] bpu_op1_i,
  input  logic [ADDR_W-1:0] bpu_op2_i,
  output logic              pc_req_vld_o,
  input  logic              pc_req_rdy_i,
  output logic [ADDR_W-1:0] pc_req_addr_o,
  input  logic              mem_rsp_vld_i,
  output logic              mem_rsp_rdy_o,
  output logic              ifu_rsp_vld_o,
  input  logic              ifu_rsp_rdy_i,
  output logic [ADDR_W-1:0] ifu_rsp_pc_o
);

  localparam int CNT_W = $clog2(MAX_OUTS + 1);
  localparam int PTR_W = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTS);

  typedef enum logic {BOOT, FETCH} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]                next_pc;
  logic [CNT_W-1:0]                 outs_cnt;
  logic [CNT_W-1:0]                 drop_cnt;
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
  logic [MAX_OUTS-1:0][ADDR_W-1:0]  pc_fifo;

  logic req_hs, mrsp_hs, out_hs, redir_bpu;
  logic has_outs, dropping;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  // FIFO occupancy always equals outs_cnt, so no response can be presented
  // while it is zero; gating on it also yields the idle output values.
  assign has_outs = (outs_cnt != '0);
  assign dropping = (drop_cnt != '0);

  assign ifu_rsp_vld_o = has_outs & ~dropping & mem_rsp_vld_i;
  assign mem_rsp_rdy_o = has_outs & (dropping | ifu_rsp_rdy_i);
  assign ifu_rsp_pc_o  = pc_fifo[rd_ptr];

  assign out_hs    = ifu_rsp_vld_o & ifu_rsp_rdy_i;
  assign mrsp_hs   = mem_rsp_vld_i & mem_rsp_rdy_o;
  assign redir_bpu = bpu_taken_i & out_hs & ~flush_vld_i;

  // Uses the registered count: a same-cycle response does not free a slot
  // until the next cycle.
  assign pc_req_vld_o  = (state == FETCH) & (outs_cnt < MAX_CNT) &
                         ~flush_vld_i & ~redir_bpu;
  assign pc_req_addr_o = next_pc;
  assign req_hs        = pc_req_vld_o & pc_req_rdy_i;

  // PC FIFO storage (data needs no reset, pointers do)
  always_ff @(posedge clk) begin
    if (req_hs) pc_fifo[wr_ptr] <= next_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_pc  <= RST_PC;
      outs_cnt <= '0;
      drop_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (req_hs)  wr_ptr <= ptr_inc(wr_ptr);
      if (mrsp_hs) rd_ptr <= ptr_inc(rd_ptr);

      outs_cnt <= outs_cnt + CNT_W'(req_hs) - CNT_W'(mrsp_hs);

      // Everything still in flight after this cycle is squashed on a
      // redirect; on a BPU redirect the current response is the one kept.
      if (flush_vld_i) begin
        next_pc  <= flush_pc_i;
        drop_cnt <= outs_cnt - CNT_W'(mrsp_hs);
      end else if (redir_bpu) begin
        next_pc  <= bpu_op1_i + bpu_op2_i;
        drop_cnt <= outs_cnt - CNT_W'(1);
      end else begin
        if (req_hs)             next_pc  <= next_pc + ADDR_W'(4);
        if (mrsp_hs && dropping) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomized + directed bench for ifu_fetch_ctrl against a queue-based
// reference: each in-flight request is a {pc, live} entry; redirects kill
// every entry still in flight, and the head entry decides the response path.
module tb_ifu_fetch_ctrl;
  localparam int MAX_OUTS = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_vld_i;
  logic [31:0] flush_pc_i;
  logic        bpu_taken_i;
  logic [31:0] bpu_op1_i, bpu_op2_i;
  logic        pc_req_vld_o, pc_req_rdy_i;
  logic [31:0] pc_req_addr_o;
  logic        mem_rsp_vld_i, mem_rsp_rdy_o;
  logic        ifu_rsp_vld_o, ifu_rsp_rdy_i;
  logic [31:0] ifu_rsp_pc_o;

  always #5 clk = ~clk;

  ifu_fetch_ctrl #(.ADDR_W(32), .RST_PC(RST_PC), .MAX_OUTS(MAX_OUTS)) dut (
    .clk(clk), .rst(rst),
    .flush_vld_i(flush_vld_i), .flush_pc_i(flush_pc_i),
    .bpu_taken_i(bpu_taken_i), .bpu_op1_i(bpu_op1_i), .bpu_op2_i(bpu_op2_i),
    .pc_req_vld_o(pc_req_vld_o), .pc_req_rdy_i(pc_req_rdy_i),
    .pc_req_addr_o(pc_req_addr_o),
    .mem_rsp_vld_i(mem_rsp_vld_i), .mem_rsp_rdy_o(mem_rsp_rdy_o),
    .ifu_rsp_vld_o(ifu_rsp_vld_o), .ifu_rsp_rdy_i(ifu_rsp_rdy_i),
    .ifu_rsp_pc_o(ifu_rsp_pc_o)
  );

  typedef struct { logic [31:0] pc; bit live; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_next;
  bit          booted;
  bit          e_req, e_mrdy, e_ivld, e_out, e_redir;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush_vld_i = 0; flush_pc_i = 0; bpu_taken_i = 0;
    bpu_op1_i = 0; bpu_op2_i = 0; pc_req_rdy_i = 0; mem_rsp_vld_i = 0; ifu_rsp_rdy_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_vld", 32'(pc_req_vld_o), 0);
    chk("rst_ifu_vld", 32'(ifu_rsp_vld_o), 0);
    chk("rst_mem_rdy", 32'(mem_rsp_rdy_o), 0);
    mq.delete();
    m_next = RST_PC;
    booted = 0;
    rst = 1'b0;
  endtask

  // Drive one cycle's inputs and compare outputs against the model.
  task automatic drive_chk(input bit fl, input logic [31:0] flpc, input bit bt,
                           input logic [31:0] o1, input logic [31:0] o2,
                           input bit prdy, input bit mvld, input bit irdy);
    @(negedge clk);
    flush_vld_i = fl; flush_pc_i = flpc; bpu_taken_i = bt;
    bpu_op1_i = o1; bpu_op2_i = o2; pc_req_rdy_i = prdy;
    mem_rsp_vld_i = mvld; ifu_rsp_rdy_i = irdy;
    #1;
    e_ivld  = (mq.size() > 0) && mq[0].live && mvld;
    e_mrdy  = (mq.size() > 0) && (!mq[0].live || irdy);
    e_out   = e_ivld && irdy;
    e_redir = bt && e_out && !fl;
    e_req   = booted && (mq.size() < MAX_OUTS) && !fl && !e_redir;
    chk("req_vld", 32'(pc_req_vld_o), 32'(e_req));
    chk("ifu_vld", 32'(ifu_rsp_vld_o), 32'(e_ivld));
    chk("mem_rdy", 32'(mem_rsp_rdy_o), 32'(e_mrdy));
    if (e_req)  chk("req_addr", pc_req_addr_o, m_next);
    if (e_ivld) chk("rsp_pc", ifu_rsp_pc_o, mq[0].pc);
  endtask

  // Advance the model across the clock edge.
  task automatic commit();
    @(posedge clk);
    if (mem_rsp_vld_i && e_mrdy) void'(mq.pop_front());
    if (flush_vld_i || e_redir) begin
      foreach (mq[i]) mq[i].live = 0;
      m_next = flush_vld_i ? flush_pc_i : bpu_op1_i + bpu_op2_i;
    end else if (e_req && pc_req_rdy_i) begin
      mq.push_back('{pc: m_next, live: 1'b1});
      m_next = m_next + 32'd4;
    end
    booted = 1;
  endtask

  task automatic step(input bit fl, input logic [31:0] flpc, input bit bt,
                      input logic [31:0] o1, input logic [31:0] o2,
                      input bit prdy, input bit mvld, input bit irdy);
    drive_chk(fl, flpc, bt, o1, o2, prdy, mvld, irdy);
    commit();
  endtask

  task automatic rnd_step();
    bit fl, bt, prdy, mvld, irdy;
    fl   = ($urandom_range(0, 19) == 0);
    bt   = ($urandom_range(0, 4) == 0);
    prdy = ($urandom_range(0, 3) != 0);
    mvld = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
    irdy = ($urandom_range(0, 3) != 0);
    step(fl, $urandom & 32'hFFFF_FFFC, bt, $urandom, $urandom, prdy, mvld, irdy);
  endtask

  initial begin
    do_reset();

    // boot: one idle cycle, then the reset vector
    drive_chk(0, 0, 0, 0, 0, 1, 0, 0);
    chk("boot_idle", 32'(pc_req_vld_o), 0);
    commit();
    drive_chk(0, 0, 0, 0, 0, 1, 0, 0);
    chk("boot_addr", pc_req_addr_o, 32'h8000_0000);
    commit();
    // 1-cycle memory, sequential stream
    drive_chk(0, 0, 0, 0, 0, 1, 1, 1);
    chk("seq_pc0", ifu_rsp_pc_o, 32'h8000_0000);
    chk("seq_addr1", pc_req_addr_o, 32'h8000_0004);
    commit();
    drive_chk(0, 0, 0, 0, 0, 1, 1, 1);
    chk("seq_pc1", ifu_rsp_pc_o, 32'h8000_0004);
    chk("seq_addr2", pc_req_addr_o, 32'h8000_0008);
    commit();
    // withhold responses: fill to MAX_OUTS
    step(0, 0, 0, 0, 0, 1, 0, 0);
    drive_chk(0, 0, 0, 0, 0, 1, 0, 0);
    chk("full_hold", 32'(pc_req_vld_o), 0);
    commit();
    // BPU redirect on the 0x8000_0008 response, one other outstanding
    drive_chk(0, 0, 1, 32'h8000_0008, 32'hFFFF_FFF0, 1, 1, 1);
    chk("bpu_pc", ifu_rsp_pc_o, 32'h8000_0008);
    chk("bpu_noreq", 32'(pc_req_vld_o), 0);
    commit();
    drive_chk(0, 0, 0, 0, 0, 0, 0, 0);
    chk("bpu_tgt", pc_req_addr_o, 32'h7FFF_FFF8);
    commit();
    drive_chk(0, 0, 0, 0, 0, 1, 1, 0);
    chk("bpu_drop", 32'(ifu_rsp_vld_o), 0);
    commit();
    step(0, 0, 0, 0, 0, 1, 0, 0);
    // flush with 2 outstanding
    step(1, 32'h8000_1000, 0, 0, 0, 1, 0, 0);
    drive_chk(0, 0, 0, 0, 0, 1, 1, 0);
    chk("fl_drop0", 32'(mem_rsp_rdy_o), 1);
    commit();
    drive_chk(0, 0, 0, 0, 0, 0, 1, 1);
    chk("fl_drop1", 32'(ifu_rsp_vld_o), 0);
    chk("fl_tgt", pc_req_addr_o, 32'h8000_1000);
    commit();
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    // flush and BPU taken together: flush wins
    drive_chk(1, 32'h8000_2000, 1, 32'h1000, 32'h2000, 1, 1, 1);
    chk("both_rsp", ifu_rsp_pc_o, 32'h8000_1000);
    commit();
    drive_chk(0, 0, 0, 0, 0, 0, 1, 1);
    chk("both_tgt", pc_req_addr_o, 32'h8000_2000);
    commit();

    repeat (1500) rnd_step();
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0, 0);
    drive_chk(0, 0, 0, 0, 0, 1, 0, 0);
    chk("reboot_addr", pc_req_addr_o, 32'h8000_0000);
    commit();
    repeat (1500) rnd_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
